// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, SDA ACK levels, default device address.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_t;

  localparam logic [6:0] I2C_DEV_ADDR_DEF = 7'h69;

  // Bus levels seen on SDA during the ninth clock of a byte.
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  function automatic logic is_ack_state(input i2c_state_t s);
    return (s == ST_ADDR_ACK) || (s == ST_REG_ACK) ||
           (s == ST_WDATA_ACK) || (s == ST_RDATA_ACK);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers plus one-flop history; emits scl_rise/scl_fall/start/stop pulses.
// Latency SYNC_STAGES+1 clk from pin to pulse; no backpressure (free-running sampler).
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_i};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_pipe[SYNC_STAGES-1];
      sda_d    <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_pipe[SYNC_STAGES-1];
  assign sda      = sda_pipe[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda;
  assign stop     = scl_s & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target: address match, register pointer, write/read bytes via a synchronous reg-file port.
// ACK/data on SDA follow SCL falls by ~SYNC_STAGES+1 clk; no backpressure (no clock stretching).
module i2c_slave_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  i2c_state_t state, state_nx;
  logic [2:0] bit_cnt, cnt_nx;
  logic       byte_done, done_nx;
  logic [7:0] shift, shift_nx;
  logic       rw, rw_nx;
  logic       mack, mack_nx;
  logic       load_pend, load_nx;
  logic       oe_nx;
  logic [7:0] addr_nx;
  logic [7:0] wdata_nx;
  logic       we_nx;
  logic       re_nx;
  logic       busy_nx;
  logic [7:0] byte_in;

  assign byte_in = {shift[6:0], sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      shift     <= '0;
      rw        <= 1'b0;
      mack      <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= cnt_nx;
      byte_done <= done_nx;
      shift     <= shift_nx;
      rw        <= rw_nx;
      mack      <= mack_nx;
      load_pend <= load_nx;
      sda_oe    <= oe_nx;
      reg_addr  <= addr_nx;
      reg_wdata <= wdata_nx;
      reg_we    <= we_nx;
      reg_re    <= re_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    done_nx  = byte_done;
    shift_nx = shift;
    rw_nx    = rw;
    mack_nx  = mack;
    load_nx  = reg_re;
    oe_nx    = sda_oe;
    addr_nx  = reg_addr;
    wdata_nx = reg_wdata;
    we_nx    = 1'b0;
    re_nx    = 1'b0;
    busy_nx  = busy;

    // The register file samples the pre-increment pointer on the same edge.
    if (reg_we) addr_nx = reg_addr + 8'd1;

    // Read data arrives the clk after reg_re; put its MSB on the bus while SCL is still low.
    if (load_pend) begin
      shift_nx = reg_rdata;
      oe_nx    = ~reg_rdata[7];
    end

    if (is_ack_state(state)) cnt_nx = '0;

    unique case (state)
      ST_ADDR, ST_REG, ST_WDATA: begin
        if (scl_rise && !byte_done) begin
          shift_nx = byte_in;
          cnt_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            done_nx = 1'b1;
            if (state == ST_ADDR) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                busy_nx = 1'b1;
                rw_nx   = byte_in[0];
              end else begin
                state_nx = ST_IDLE;
                done_nx  = 1'b0;
              end
            end
          end
        end else if (scl_fall && byte_done) begin
          done_nx = 1'b0;
          oe_nx   = ~SDA_ACK;
          if (state == ST_ADDR) begin
            state_nx = ST_ADDR_ACK;
          end else if (state == ST_REG) begin
            state_nx = ST_REG_ACK;
            addr_nx  = shift;
          end else begin
            state_nx = ST_WDATA_ACK;
            wdata_nx = shift;
            we_nx    = 1'b1;
          end
        end
      end

      ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
        if (scl_fall) begin
          oe_nx = 1'b0;
          if (state == ST_ADDR_ACK) begin
            if (rw) begin
              state_nx = ST_RDATA;
              re_nx    = 1'b1;
            end else begin
              state_nx = ST_REG;
            end
          end else begin
            state_nx = ST_WDATA;
          end
        end
      end

      ST_RDATA: begin
        if (scl_rise && !byte_done) begin
          cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) done_nx = 1'b1;
        end else if (scl_fall) begin
          if (byte_done) begin
            done_nx  = 1'b0;
            oe_nx    = 1'b0;
            addr_nx  = reg_addr + 8'd1;
            state_nx = ST_RDATA_ACK;
          end else begin
            shift_nx = {shift[6:0], 1'b0};
            oe_nx    = ~shift[6];
          end
        end
      end

      ST_RDATA_ACK: begin
        if (scl_rise) begin
          mack_nx = (sda == SDA_ACK);
        end else if (scl_fall) begin
          if (mack) begin
            state_nx = ST_RDATA;
            re_nx    = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
      end

      default: state_nx = ST_IDLE;
    endcase

    // Bus conditions override everything; the pointer survives both.
    if (stop || start) begin
      state_nx = stop ? ST_IDLE : ST_ADDR;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      cnt_nx   = '0;
      load_nx  = 1'b0;
      we_nx    = 1'b0;
      re_nx    = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bit-banged I2C master against i2c_slave_regif with a register-file model and transaction-level reference.
module tb_i2c_slave_regif;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h69;
  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regif dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Register file plus bus monitors, all sampled on the falling clock edge.
  bit   [7:0]  mem [256];
  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];
  int          oe_cnt = 0;
  int          viol = 0;
  bit          mon_en = 1'b1;
  logic        oe_prev = 1'b0;
  logic        scl_prev = 1'b1;

  always @(negedge clk) begin
    if (reg_we) begin
      mem[reg_addr] = reg_wdata;
      we_log.push_back({reg_addr, reg_wdata});
    end
    if (reg_re) begin
      reg_rdata = mem[reg_addr];
      re_log.push_back(reg_addr);
    end
    if (sda_oe) oe_cnt++;
    if (mon_en && (sda_oe !== oe_prev) && scl_prev) viol++;
    oe_prev  = sda_oe;
    scl_prev = scl_m;
  end

  // Reference model: expected register contents and pointer.
  bit   [7:0] exp_mem [256];
  logic [7:0] exp_ptr = 8'h00;
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] b, output logic ack);
    logic ab;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ab);
    ack = (ab == SDA_ACK);
  endtask

  task automatic get_byte(output logic [7:0] b, input logic more);
    logic bb;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bb);
      b[i] = bb;
    end
    put_bit(more ? SDA_ACK : SDA_NACK);
  endtask

  task automatic wr_txn(input logic [6:0] a, input logic [7:0] ptr, input int n,
                        input logic [7:0] d [4], input int tail);
    logic        ack;
    int          wb, ob;
    logic [15:0] exp_w[$];
    wb = we_log.size();
    ob = oe_cnt;
    bus_start();
    put_byte({a, 1'b0}, ack);
    check("addr_ack", ack, a == DEV);
    if (a != DEV) begin
      check("nomatch_busy", busy, 1'b0);
      put_byte(ptr, ack);
      check("nomatch_byte_ack", ack, 1'b0);
      bus_stop();
      check("nomatch_oe_cycles", oe_cnt - ob, 0);
      check("nomatch_we", we_log.size() - wb, 0);
      check("nomatch_ptr", reg_addr, exp_ptr);
      return;
    end
    check("busy_after_match", busy, 1'b1);
    put_byte(ptr, ack);
    check("reg_ack", ack, 1'b1);
    exp_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      put_byte(d[i], ack);
      check("data_ack", ack, 1'b1);
      exp_mem[exp_ptr] = d[i];
      exp_w.push_back({exp_ptr, d[i]});
      exp_ptr = exp_ptr + 8'd1;
    end
    for (int i = 0; i < tail; i++) put_bit(1'($urandom_range(0, 1)));
    bus_stop();
    check("busy_after_stop", busy, 1'b0);
    check("we_count", we_log.size() - wb, exp_w.size());
    for (int i = 0; i < exp_w.size() && wb + i < we_log.size(); i++)
      check("we_addr_data", we_log[wb + i], exp_w[i]);
    check("ptr_after_wr", reg_addr, exp_ptr);
  endtask

  task automatic rd_txn(input bit set_ptr, input logic [7:0] ptr, input int n, input int abort);
    logic       ack;
    logic [7:0] b, p;
    int         rb, wb;
    logic [7:0] exp_r[$];
    rb = re_log.size();
    wb = we_log.size();
    bus_start();
    if (set_ptr) begin
      put_byte({DEV, 1'b0}, ack);
      check("rd_waddr_ack", ack, 1'b1);
      put_byte(ptr, ack);
      check("rd_reg_ack", ack, 1'b1);
      exp_ptr = ptr;
      for (int i = 0; i < abort; i++) put_bit(1'($urandom_range(0, 1)));
      bus_start();
    end
    put_byte({DEV, 1'b1}, ack);
    check("rd_addr_ack", ack, 1'b1);
    check("rd_busy", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      p = exp_ptr;
      get_byte(b, i < n - 1);
      check("rd_data", b, exp_mem[p]);
      exp_r.push_back(p);
      exp_ptr = exp_ptr + 8'd1;
    end
    check("rd_sda_released", sda_oe, 1'b0);
    bus_stop();
    check("rd_busy_after_stop", busy, 1'b0);
    check("rd_no_we", we_log.size() - wb, 0);
    check("re_count", re_log.size() - rb, n);
    for (int i = 0; i < n && rb + i < re_log.size(); i++)
      check("re_addr", re_log[rb + i], exp_r[i]);
    check("ptr_after_rd", reg_addr, exp_ptr);
  endtask

  initial begin
    logic [7:0] d [4];
    logic       bb;
    logic [6:0] a;
    int         kind;

    tick(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_reg_re", reg_re, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick(8);

    d = '{8'h96, 8'h00, 8'h00, 8'h00};
    wr_txn(DEV, 8'h25, 1, d, 0);
    d = '{8'h14, 8'h15, 8'h00, 8'h00};
    wr_txn(DEV, 8'h25, 2, d, 0);
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    wr_txn(DEV, 8'h10, 2, d, 0);
    rd_txn(1'b1, 8'h10, 2, 0);
    wr_txn(7'h68, 8'h33, 1, d, 0);
    d = '{8'hC3, 8'h00, 8'h00, 8'h00};
    wr_txn(DEV, 8'hFF, 1, d, 4);
    rd_txn(1'b0, 8'h00, 2, 0);
    rd_txn(1'b1, 8'h25, 2, 3);

    // Asynchronous reset while the target is pulling SDA for a read data bit.
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    wr_txn(DEV, 8'h40, 2, d, 0);
    bus_start();
    put_byte({DEV, 1'b0}, bb);
    put_byte(8'h40, bb);
    bus_start();
    put_byte({DEV, 1'b1}, bb);
    get_bit(bb);
    tick(Q);
    check("pre_rst_sda_oe", sda_oe, 1'b1);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_reg_addr", reg_addr, 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    mon_en = 1'b1;
    exp_ptr = 8'h00;
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    wr_txn(DEV, 8'h07, 1, d, 0);

    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        a = ($urandom_range(0, 4) == 0) ? (DEV ^ 7'($urandom_range(1, 127))) : DEV;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        wr_txn(a, 8'($urandom_range(8'hF8, 8'hFF)), $urandom_range(1, 3), d,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
      end else if (kind == 2) begin
        rd_txn(1'b1, 8'($urandom_range(8'hF8, 8'hFF)), $urandom_range(1, 3),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);
      end else begin
        rd_txn(1'b0, 8'h00, $urandom_range(1, 3), 0);
      end
    end

    check("sda_stable_while_scl_high", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
